wb_spraid_master: RTL and testbench

Wishbone initiator for the SPI RAID subsystem. It converts a simple valid/ready command port into single Wishbone read or write cycles toward `wb_spraid` and returns read data or an error through a valid/ready response port. Each cycle holds `cyc`/`stb` until the responder acks, errors or stalls out. It sits between an internal sequencer or CPU-side bridge and the `wb_spraid` responder.

---
 rtl/wb_spraid_master.sv | 196 +++++++++++++++++++
 tb/tb_wb_spraid_master.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_spraid_master.sv
`default_nettype none
// ============================================================================
// wb_spraid_master : valid/ready command port to single Wishbone cycles.
// Optional REQ-state timeout abort enabled by WB_MASTER_TIMEOUT_EN. Rev 1.0
// ============================================================================
module wb_spraid_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_stall_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout_cycles
    $error("wb_spraid_master: TIMEOUT_CYCLES must be within 1..65535");
  end

  state_t      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  logic        rsp_err_q, rsp_err_d;
  logic        busy_q, busy_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        timeout_w;

  // Stall only delays the ack; stb stays up and the cycle still counts.
  logic unused_stall;
  assign unused_stall = wb_stall_i;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
  assign timeout_w = (cnt_q == TO_LAST);
`else
  assign timeout_w = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    busy_d      = busy_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
`ifdef WB_MASTER_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid_i && cmd_ready_q) begin
          state_d     = ST_REQ;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          cyc_d       = 1'b1;
          we_d        = cmd_we_i;
          adr_d       = cmd_adr_i;
          dat_d       = cmd_dat_i;
`ifdef WB_MASTER_TIMEOUT_EN
          cnt_d       = 16'd0;
`endif
        end
      end
      ST_REQ: begin
        if (wb_err_i || wb_rty_i) begin
          state_d     = ST_RESP;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = 32'd0;
        end else if (wb_ack_i) begin
          state_d     = ST_RESP;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_dat_d   = we_q ? 32'd0 : wb_dat_i;
        end else if (timeout_w) begin
          state_d     = ST_RESP;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = 32'd0;
        end else begin
`ifdef WB_MASTER_TIMEOUT_EN
          if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end
`endif
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_dat_d   = 32'd0;
          busy_d      = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_dat_d   = 32'd0;
        busy_d      = 1'b0;
        cyc_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= 32'd0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= 32'd0;
      dat_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
    end
  end

`ifdef WB_MASTER_TIMEOUT_EN
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = busy_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = 4'hF;

endmodule
`default_nettype wire

// File: tb/tb_wb_spraid_master.sv
`default_nettype none
// ============================================================================
// tb_wb_spraid_master : directed self-checking bench for wb_spraid_master.
// Rev 1.0
// ============================================================================
module tb_wb_spraid_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_dat;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;
  logic        wb_ack, wb_stall, wb_err, wb_rty;

  int errors = 0;
  int checks = 0;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int STALL_N = 6;   // must stay below the 8-cycle timeout
`else
  localparam int STALL_N = 20;
`endif

  always #5 clk = ~clk;

  wb_spraid_master #(.TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_we_i   (cmd_we),
    .cmd_adr_i  (cmd_adr),
    .cmd_dat_i  (cmd_dat),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_dat_o  (rsp_dat),
    .rsp_err_o  (rsp_err),
    .busy_o     (busy),
    .wb_cyc_o   (wb_cyc),
    .wb_stb_o   (wb_stb),
    .wb_we_o    (wb_we),
    .wb_adr_o   (wb_adr),
    .wb_dat_o   (wb_dat_o),
    .wb_sel_o   (wb_sel),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack),
    .wb_stall_i (wb_stall),
    .wb_err_i   (wb_err),
    .wb_rty_i   (wb_rty)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // Accept a command; afterwards the bench sits in the first REQ cycle.
  task automatic issue(input string nm, input logic we, input logic [31:0] adr,
                       input logic [31:0] dat);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: cmd_ready=%b required 1", nm, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat;
    tick();
    cmd_valid = 1'b0; cmd_adr = 32'h0; cmd_dat = 32'h0; cmd_we = 1'b0;
    checks++;
    if ({wb_cyc, wb_stb, wb_we, busy, cmd_ready, rsp_valid, wb_adr, wb_dat_o} !==
        {1'b1, 1'b1, we, 1'b1, 1'b0, 1'b0, adr, dat}) begin
      errors++;
      $display("FAIL %s_req: cyc/stb/we/busy/rdy/rv=%b%b%b%b%b%b adr=%h dat=%h required 11%b100 adr=%h dat=%h",
               nm, wb_cyc, wb_stb, wb_we, busy, cmd_ready, rsp_valid, wb_adr, wb_dat_o, we, adr, dat);
    end
  endtask

  // Check the presented response, consume it, check the return to IDLE.
  task automatic finish_rsp(input string nm, input logic [31:0] exp_dat, input logic exp_err);
    checks++;
    if ({rsp_valid, wb_cyc, wb_stb, rsp_err, rsp_dat} !== {1'b1, 1'b0, 1'b0, exp_err, exp_dat}) begin
      errors++;
      $display("FAIL %s_rsp: valid=%b cyc=%b stb=%b err=%b dat=%h required valid=1 cyc=0 stb=0 err=%b dat=%h",
               nm, rsp_valid, wb_cyc, wb_stb, rsp_err, rsp_dat, exp_err, exp_dat);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL %s_done: valid/cmd_ready/busy=%b%b%b required 010", nm, rsp_valid, cmd_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 32'h0; cmd_dat = 32'h0;
    rsp_ready = 1'b0; wb_dat_i = 32'h0;
    wb_ack = 1'b0; wb_stall = 1'b0; wb_err = 1'b0; wb_rty = 1'b0;
    tick(); tick();
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, busy, wb_cyc, wb_stb, wb_we, wb_sel, rsp_dat, wb_adr, wb_dat_o} !==
        {7'b0, 4'hF, 96'h0}) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b rv=%b err=%b busy=%b cyc=%b stb=%b we=%b sel=%h dat=%h adr=%h wdat=%h required all 0, sel=f",
               cmd_ready, rsp_valid, rsp_err, busy, wb_cyc, wb_stb, wb_we, wb_sel, rsp_dat, wb_adr, wb_dat_o);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    issue("write", 1'b1, 32'h3000_0800, 32'h0000_0002);
    tick();
    checks++;
    if ({wb_stb, rsp_valid, wb_dat_o} !== {2'b10, 32'h2}) begin
      errors++;
      $display("FAIL write_hold: stb=%b rv=%b wdat=%h required stb=1 rv=0 wdat=00000002", wb_stb, rsp_valid, wb_dat_o);
    end
    wb_ack = 1'b1; wb_dat_i = 32'hFFFF_FFFF;
    tick();
    wb_ack = 1'b0; wb_dat_i = 32'h0;
    finish_rsp("write", 32'h0, 1'b0);
  endtask

  task automatic test_read();
    issue("read", 1'b0, 32'h3000_0800, 32'h0);
    wb_ack = 1'b1; wb_dat_i = 32'h0000_0002;
    tick();
    wb_ack = 1'b0; wb_dat_i = 32'h0;
    finish_rsp("read", 32'h0000_0002, 1'b0);
  endtask

  task automatic test_stall();
    int bad = 0;
    issue("stall", 1'b0, 32'h3000_0010, 32'h0);
    wb_stall = 1'b1;
    for (int i = 0; i < STALL_N; i++) begin
      tick();
      if (wb_stb !== 1'b1 || rsp_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold: %0d cycles lost stb or showed response, required 0", bad);
    end
    wb_stall = 1'b0; wb_ack = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
    tick();
    wb_ack = 1'b0; wb_dat_i = 32'h0;
    finish_rsp("stall", 32'hDEAD_BEEF, 1'b0);
  endtask

  task automatic test_timeout();
    int early = 0;
    int idle_w = 0;
    issue("timeout", 1'b0, 32'h3000_0020, 32'h0);
`ifdef WB_MASTER_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      tick();
      if (rsp_valid !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL timeout_early: response seen %0d cycles early, required 0", early);
    end
    tick();
    finish_rsp("timeout", 32'h0, 1'b1);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      if (rsp_valid !== 1'b0) early++;
      if (wb_stb !== 1'b1) idle_w++;
    end
    checks++;
    if (early != 0 || idle_w != 0) begin
      errors++;
      $display("FAIL no_timeout: %0d response cycles, %0d stb-low cycles, required 0 and 0", early, idle_w);
    end
    wb_ack = 1'b1; wb_dat_i = 32'h1234_5678;
    tick();
    wb_ack = 1'b0; wb_dat_i = 32'h0;
    finish_rsp("late_ack", 32'h1234_5678, 1'b0);
`endif
  endtask

  task automatic test_err_vs_ack();
    issue("errack", 1'b0, 32'h3000_0040, 32'h0);
    wb_ack = 1'b1; wb_err = 1'b1; wb_dat_i = 32'hA5A5_A5A5;
    tick();
    wb_err = 1'b0;
    // Ack deliberately left high through RESP and the next accept edge.
    finish_rsp("errack", 32'h0, 1'b1);
    issue("stale", 1'b0, 32'h3000_0044, 32'h0);
    wb_ack = 1'b0;
    tick();
    checks++;
    if ({rsp_valid, wb_stb} !== 2'b01) begin
      errors++;
      $display("FAIL stale_ack: rv=%b stb=%b required rv=0 stb=1", rsp_valid, wb_stb);
    end
    wb_ack = 1'b1; wb_dat_i = 32'h0BAD_F00D;
    tick();
    wb_ack = 1'b0; wb_dat_i = 32'h0;
    finish_rsp("fresh_ack", 32'h0BAD_F00D, 1'b0);
    issue("rty", 1'b1, 32'h3000_0048, 32'h7);
    wb_rty = 1'b1;
    tick();
    wb_rty = 1'b0;
    finish_rsp("rty", 32'h0, 1'b1);
  endtask

  task automatic test_reset_mid();
    issue("rstmid", 1'b1, 32'h3000_0080, 32'hCAFE_0001);
    tick();
    rst_n = 1'b0; wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    checks++;
    if ({wb_cyc, wb_stb, busy, cmd_ready, rsp_valid, wb_adr} !== {5'b0, 32'h0}) begin
      errors++;
      $display("FAIL rstmid_outputs: cyc/stb/busy/rdy/rv=%b%b%b%b%b adr=%h required 00000 adr=0",
               wb_cyc, wb_stb, busy, cmd_ready, rsp_valid, wb_adr);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({cmd_ready, rsp_valid, wb_cyc} !== 3'b100) begin
      errors++;
      $display("FAIL rstmid_release: rdy/rv/cyc=%b%b%b required 100", cmd_ready, rsp_valid, wb_cyc);
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    issue("bp", 1'b0, 32'h3000_00C0, 32'h0);
    wb_ack = 1'b1; wb_dat_i = 32'h55AA_1234;
    tick();
    wb_ack = 1'b0; wb_dat_i = 32'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ({rsp_valid, rsp_err, cmd_ready, rsp_dat} !== {3'b100, 32'h55AA_1234}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL backpressure: %0d unstable cycles, required 0", bad);
    end
    finish_rsp("bp", 32'h55AA_1234, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      issue("b2b", 1'b1, 32'h3000_0100 + 32'(i * 4), 32'h100 + 32'(i));
      wb_ack = 1'b1;
      tick();
      wb_ack = 1'b0;
      finish_rsp("b2b", 32'h0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_stall();
    test_timeout();
    test_err_vs_ack();
    test_reset_mid();
    test_backpressure();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
